// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared types and defaults for the 2x2 systolic array feeder.
package systolic_feeder_2x2_pkg;

    localparam int unsigned DefDw     = 32;
    localparam int unsigned DefFlush  = 2;
    localparam int unsigned DefClrLen = 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed0,
        StFeed1,
        StFeed2,
        StFlush,
        StDone
    } state_e;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/systolic_feeder_2x2.sv
// Transmit side of the 2x2 systolic array: latches one A/B job and drives the
// diagonally skewed operand stream, accumulator clear and done pulse.
module systolic_feeder_2x2
    import systolic_feeder_2x2_pkg::*;
#(
    parameter int unsigned DW      = DefDw,
    parameter int unsigned FLUSH   = DefFlush,
    parameter int unsigned CLR_LEN = DefClrLen
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4*DW-1:0] a_flat,
    input  logic [4*DW-1:0] b_flat,
    output logic          arr_clr,
    output logic          load_in,
    output logic [DW-1:0] mat1_row0,
    output logic [DW-1:0] mat1_row1,
    output logic [DW-1:0] mat2_col0,
    output logic [DW-1:0] mat2_col1,
    output logic          busy,
    output logic          done
);

    localparam int unsigned ClrW   = cnt_w(CLR_LEN);
    localparam int unsigned FlushW = cnt_w(FLUSH);
    localparam logic [ClrW-1:0]   ClrLast   = ClrW'(CLR_LEN - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH > 0 ? FLUSH - 1 : 0);

    state_e              state_q;
    logic [4*DW-1:0]     a_q;
    logic [4*DW-1:0]     b_q;
    logic [ClrW-1:0]     clr_cnt_q;
    logic [FlushW-1:0]   flush_cnt_q;

    logic [DW-1:0] a00, a01, a10, a11;
    logic [DW-1:0] b00, b01, b10, b11;

    assign a00 = a_q[0*DW +: DW];
    assign a01 = a_q[1*DW +: DW];
    assign a10 = a_q[2*DW +: DW];
    assign a11 = a_q[3*DW +: DW];
    assign b00 = b_q[0*DW +: DW];
    assign b01 = b_q[1*DW +: DW];
    assign b10 = b_q[2*DW +: DW];
    assign b11 = b_q[3*DW +: DW];

    assign in_ready = (state_q == StIdle);

    // Outputs are loaded on the edge that enters each state, so they track state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            clr_cnt_q   <= '0;
            flush_cnt_q <= '0;
            arr_clr     <= 1'b0;
            load_in     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mat1_row0   <= '0;
            mat1_row1   <= '0;
            mat2_col0   <= '0;
            mat2_col1   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q       <= a_flat;
                        b_q       <= b_flat;
                        clr_cnt_q <= '0;
                        arr_clr   <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    if (clr_cnt_q == ClrLast) begin
                        arr_clr   <= 1'b0;
                        load_in   <= 1'b1;
                        mat1_row0 <= a00;
                        mat2_col0 <= b00;
                        state_q   <= StFeed0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                StFeed0: begin
                    mat1_row0 <= a01;
                    mat2_col0 <= b10;
                    mat1_row1 <= a10;
                    mat2_col1 <= b01;
                    state_q   <= StFeed1;
                end
                StFeed1: begin
                    mat1_row0 <= '0;
                    mat2_col0 <= '0;
                    mat1_row1 <= a11;
                    mat2_col1 <= b11;
                    state_q   <= StFeed2;
                end
                StFeed2: begin
                    mat1_row1 <= '0;
                    mat2_col1 <= '0;
                    if (FLUSH == 0) begin
                        load_in <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        flush_cnt_q <= '0;
                        state_q     <= StFlush;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == FlushLast) begin
                        load_in <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Scoreboard bench: per-cycle expected output records are queued on each accept
// and compared by a negedge monitor; a second FLUSH=0 instance checks latency.
module tb_systolic_feeder_2x2;

    localparam int unsigned DW       = 32;
    localparam int unsigned FLUSH    = 2;
    localparam int unsigned CLR_LEN  = 1;
    localparam int unsigned CLR_LEN2 = 2;

    typedef struct packed {
        logic          clr;
        logic          load;
        logic          done;
        logic          busy;
        logic          ready;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [4*DW-1:0] a_flat = '0;
    logic [4*DW-1:0] b_flat = '0;
    logic arr_clr, load_in, busy, done;
    logic [DW-1:0] mat1_row0, mat1_row1, mat2_col0, mat2_col1;

    logic in_valid2 = 1'b0;
    logic in_ready2;
    logic [4*DW-1:0] a_flat2 = '0;
    logic [4*DW-1:0] b_flat2 = '0;
    logic arr_clr2, load_in2, busy2, done2;
    logic [DW-1:0] r0_2, r1_2, c0_2, c1_2;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    bit cur_idle = 1'b1;
    rec_t exp_q[$];
    rec_t exp_r, act_r;

    always #5 clk = ~clk;

    systolic_feeder_2x2 #(.DW(DW), .FLUSH(FLUSH), .CLR_LEN(CLR_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .b_flat(b_flat), .arr_clr(arr_clr), .load_in(load_in),
        .mat1_row0(mat1_row0), .mat1_row1(mat1_row1),
        .mat2_col0(mat2_col0), .mat2_col1(mat2_col1), .busy(busy), .done(done)
    );

    systolic_feeder_2x2 #(.DW(DW), .FLUSH(0), .CLR_LEN(CLR_LEN2)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_flat(a_flat2), .b_flat(b_flat2), .arr_clr(arr_clr2), .load_in(load_in2),
        .mat1_row0(r0_2), .mat1_row1(r1_2), .mat2_col0(c0_2), .mat2_col1(c1_2),
        .busy(busy2), .done(done2)
    );

    function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] m, input int i, input int j);
        return m[(2*i+j)*DW +: DW];
    endfunction

    // Beat t carries A[i][t-i] on row i and B[t-j][j] on column j (diagonal skew).
    function automatic void push_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        rec_t r;
        for (int c = 0; c < int'(CLR_LEN); c++) begin
            r = '0; r.clr = 1'b1; r.busy = 1'b1;
            exp_q.push_back(r);
        end
        for (int t = 0; t < 3; t++) begin
            r = '0; r.load = 1'b1; r.busy = 1'b1;
            if (t < 2) r.r0 = elem(a, 0, t);
            if (t >= 1) r.r1 = elem(a, 1, t - 1);
            if (t < 2) r.c0 = elem(b, t, 0);
            if (t >= 1) r.c1 = elem(b, t - 1, 1);
            exp_q.push_back(r);
        end
        for (int f = 0; f < int'(FLUSH); f++) begin
            r = '0; r.load = 1'b1; r.busy = 1'b1;
            exp_q.push_back(r);
        end
        r = '0; r.done = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
    endfunction

    always @(posedge clk) begin
        if (!rst && in_valid && cur_idle) begin
            push_job(a_flat, b_flat);
            acc_cnt++;
        end
    end

    always @(negedge clk) begin
        act_r = {arr_clr, load_in, done, busy, in_ready,
                 mat1_row0, mat1_row1, mat2_col0, mat2_col1};
        if (exp_q.size() > 0) begin
            exp_r = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            exp_r = '0;
            exp_r.ready = 1'b1;
            cur_idle = 1'b1;
        end
        n_checks++;
        if (act_r !== exp_r) begin
            n_fail++;
            $display("FAIL trace @%0t: actual %h required %h", $time, act_r, exp_r);
        end
    end

    task automatic issue(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit keep);
        int start;
        bit ok;
        start = acc_cnt;
        ok = 1'b0;
        a_flat = a;
        b_flat = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!keep) in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept: actual not accepted required accepted within 50 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && cur_idle) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d records pending required 0", exp_q.size());
        end
    endtask

    function automatic logic [4*DW-1:0] rnd_mat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [4*DW-1:0] a1, b1, ident, b3, all1;
        int loads, clrs, done_at;
        a1    = {32'd4, 32'd3, 32'd2, 32'd1};
        b1    = {32'd8, 32'd7, 32'd6, 32'd5};
        ident = {32'd1, 32'd0, 32'd0, 32'd1};
        b3    = {32'd6, 32'd7, 32'd8, 32'd9};
        all1  = '1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed jobs, including back-to-back with in_valid held high.
        issue(a1, b1, 1'b0);
        wait_idle();
        issue(all1, all1, 1'b0);
        wait_idle();
        issue(a1, b1, 1'b1);
        issue(ident, b3, 1'b0);
        wait_idle();

        // in_valid pulse during FEED1 with different data must be ignored.
        issue(a1, b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_flat = all1; b_flat = all1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset during FEED1 aborts the job; a re-issued job then completes.
        issue(all1, b3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        cur_idle = 1'b1;
        #1;
        n_checks++;
        if ({arr_clr, load_in, done, busy, mat1_row0, mat1_row1, mat2_col0, mat2_col1} !== '0
            || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_abort: actual busy=%b load=%b ready=%b required 0 0 1",
                     busy, load_in, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        issue(all1, b3, 1'b0);
        wait_idle();

        // Randomised jobs with idle gaps, held valid and stray pulses.
        for (int k = 0; k < 20; k++) begin
            issue(rnd_mat(), rnd_mat(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                a_flat = rnd_mat(); b_flat = rnd_mat(); in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // FLUSH=0 instance: done exactly CLR_LEN+4 cycles after accept, load_in for 3.
        n_checks++;
        if (in_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL nf_ready: actual %b required 1", in_ready2);
        end
        a_flat2 = a1; b_flat2 = b1; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        loads = 0; clrs = 0; done_at = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (load_in2) loads++;
            if (arr_clr2) clrs++;
            if (done2 && done_at == 0) done_at = n;
        end
        n_checks++;
        if (done_at != int'(CLR_LEN2) + 4) begin
            n_fail++;
            $display("FAIL nf_latency: actual %0d required %0d", done_at, CLR_LEN2 + 4);
        end
        n_checks++;
        if (loads != 3) begin
            n_fail++;
            $display("FAIL nf_load_cycles: actual %0d required 3", loads);
        end
        n_checks++;
        if (clrs != int'(CLR_LEN2)) begin
            n_fail++;
            $display("FAIL nf_clr_cycles: actual %0d required %0d", clrs, CLR_LEN2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
